// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-predictor definitions. Holds the clear-sweep
//                FSM state encoding and the default counter geometry that the
//                predictor tables reuse.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Clear-sweep controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bp_clr_state_e;

  // Default counter width and reset/clear value ("weakly not taken").
  localparam int BP_CTR_W    = 2;
  localparam int BP_INIT_VAL = 1;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/sat_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter_next
//  Description : Combinational successor of a saturating counter. Taken
//                increments, not-taken decrements, and the value sticks at
//                the all-ones and zero limits instead of wrapping.
//  Ports       : c_i     - current counter value
//                taken_i - resolved direction (1 = increment)
//                c_o     - saturated next value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_next #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] c_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] c_o
);

  localparam logic [CTR_W-1:0] C_MAX = '1;

  always_comb begin
    c_o = c_i;
    if (taken_i) begin
      if (c_i != C_MAX) c_o = c_i + 1'b1;
    end else begin
      if (c_i != '0) c_o = c_i - 1'b1;
    end
  end

endmodule : sat_counter_next
`default_nettype wire

// File: rtl/sat_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter_table
//  Description : Pattern history table of DEPTH saturating counters. Fetch
//                looks a counter up (registered response, write-first against
//                a same-cycle update), branch resolve trains one counter per
//                cycle, and a clear request sweeps INIT_VAL over every entry.
//  Ports       : clk, rstn           - clock, synchronous active-low reset
//                pred_valid/index    - lookup request
//                pred_resp_valid     - response valid one cycle after request
//                pred_taken/counter  - looked-up counter MSB / full value
//                upd_valid/index     - training request
//                upd_taken           - resolved direction
//                clear_req           - start a whole-table clear sweep
//                busy                - clear sweep in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int CTR_W    = BP_CTR_W,
  parameter int DEPTH    = 16,
  parameter int INIT_VAL = BP_INIT_VAL,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_index,
  output logic             pred_resp_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_counter,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Flop storage so that reset and the clear sweep can reach every entry.
  logic [CTR_W-1:0] table_q [DEPTH];

  bp_clr_state_e    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             is_idle;
  logic             upd_accept;
  logic             pred_accept;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_new;
  logic [CTR_W-1:0] lookup_val;

  logic             resp_valid_q;
  logic [CTR_W-1:0] resp_ctr_q;

  // --------------------------------------------------------------------------
  // Request qualification. A clear raised in IDLE wins over a same-cycle
  // update, but a same-cycle lookup still reads the pre-clear table.
  // --------------------------------------------------------------------------
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    upd_accept  = upd_valid  && is_idle && !clear_req;
    pred_accept = pred_valid && is_idle;
  end

  // Single update path through the saturating successor.
  assign upd_cur = table_q[upd_index];

  sat_counter_next #(
    .CTR_W (CTR_W)
  ) u_next (
    .c_i     (upd_cur),
    .taken_i (upd_taken),
    .c_o     (upd_new)
  );

  // Write-first bypass: a lookup colliding with an accepted update returns
  // the post-update value.
  always_comb begin
    if (upd_accept && (upd_index == pred_index)) lookup_val = upd_new;
    else                                         lookup_val = table_q[pred_index];
  end

  // --------------------------------------------------------------------------
  // Counter storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rstn) begin
        table_q[i] <= INIT_CTR;
      end else if (!is_idle) begin
        if (ptr_q == IDX_W'(i)) table_q[i] <= INIT_CTR;
      end else if (upd_accept && (upd_index == IDX_W'(i))) begin
        table_q[i] <= upd_new;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Clear-sweep controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Registered prediction response; the value holds between lookups.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid_q <= 1'b0;
      resp_ctr_q   <= '0;
    end else begin
      resp_valid_q <= pred_accept;
      if (pred_accept) resp_ctr_q <= lookup_val;
    end
  end

  assign pred_resp_valid = resp_valid_q;
  assign pred_counter    = resp_ctr_q;
  assign pred_taken      = resp_ctr_q[CTR_W-1];

endmodule : sat_counter_table
`default_nettype wire

// File: tb/tb_sat_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sat_counter_table
//  Description : Self-checking bench for sat_counter_table. A table-of-ints
//                reference model tracks the default instance every cycle;
//                directed sequences pin known values; a second instance with
//                CTR_W=3, DEPTH=4, INIT_VAL=3 covers a non-default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_counter_table;

  localparam int CTR_W    = 2;
  localparam int DEPTH    = 16;
  localparam int INIT_VAL = 1;
  localparam int MAXV     = (1 << CTR_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       pred_valid;
  logic [3:0] pred_index;
  logic       pred_resp_valid;
  logic       pred_taken;
  logic [1:0] pred_counter;
  logic       upd_valid;
  logic [3:0] upd_index;
  logic       upd_taken;
  logic       clear_req;
  logic       busy;

  logic       p2_valid;
  logic [1:0] p2_index;
  logic       p2_resp_valid;
  logic       p2_taken;
  logic [2:0] p2_counter;
  logic       u2_valid;
  logic [1:0] u2_index;
  logic       u2_taken;
  logic       c2_req;
  logic       p2_busy;

  sat_counter_table #(.CTR_W(CTR_W), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .pred_valid      (pred_valid),
    .pred_index      (pred_index),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .pred_counter    (pred_counter),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .clear_req       (clear_req),
    .busy            (busy)
  );

  sat_counter_table #(.CTR_W(3), .DEPTH(4), .INIT_VAL(3)) dut2 (
    .clk             (clk),
    .rstn            (rstn),
    .pred_valid      (p2_valid),
    .pred_index      (p2_index),
    .pred_resp_valid (p2_resp_valid),
    .pred_taken      (p2_taken),
    .pred_counter    (p2_counter),
    .upd_valid       (u2_valid),
    .upd_index       (u2_index),
    .upd_taken       (u2_taken),
    .clear_req       (c2_req),
    .busy            (p2_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: plain array of counter values plus expected outputs.
  int mdl [DEPTH];
  int exp_valid = 0;
  int exp_ctr   = 0;
  int clr_left  = 0;
  bit cmp_en    = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = INIT_VAL;
      exp_valid = 0;
      exp_ctr   = 0;
      clr_left  = 0;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_valid = 0;
    end else begin
      if (upd_valid && !clear_req) begin
        if (upd_taken) mdl[upd_index] = (mdl[upd_index] < MAXV) ? mdl[upd_index] + 1 : MAXV;
        else           mdl[upd_index] = (mdl[upd_index] > 0)    ? mdl[upd_index] - 1 : 0;
      end
      if (pred_valid) begin
        exp_valid = 1;
        exp_ctr   = mdl[pred_index];
      end else begin
        exp_valid = 0;
      end
      if (clear_req) begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = INIT_VAL;
        clr_left = DEPTH;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_index = '0;
    upd_valid  = 1'b0; upd_index  = '0; upd_taken = 1'b0;
    clear_req  = 1'b0;
  endtask

  task automatic lookup(input int idx);
    pred_valid = 1'b1;
    pred_index = 4'(idx);
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic train(input int idx, input bit t);
    upd_valid = 1'b1;
    upd_index = 4'(idx);
    upd_taken = t;
    tick();
    upd_valid = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("resp_valid",   int'(pred_resp_valid), exp_valid);
      check("pred_counter", int'(pred_counter),    exp_ctr);
      check("pred_taken",   int'(pred_taken),      (exp_ctr >= (1 << (CTR_W - 1))) ? 1 : 0);
      check("busy",         int'(busy),            (clr_left > 0) ? 1 : 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int e2;
    bit t;

    rstn = 1'b0;
    idle_inputs();
    p2_valid = 1'b0; p2_index = '0;
    u2_valid = 1'b0; u2_index = '0; u2_taken = 1'b0;
    c2_req   = 1'b0;

    repeat (3) tick();
    cmp_en = 1'b1;
    check("reset_valid", int'(pred_resp_valid), 0);
    check("reset_ctr",   int'(pred_counter),    0);
    check("reset_busy",  int'(busy),            0);
    rstn = 1'b1;

    // Fresh table reads INIT_VAL everywhere.
    lookup(5);
    check("lk5_valid", int'(pred_resp_valid), 1);
    check("lk5_ctr",   int'(pred_counter),    1);
    check("lk5_taken", int'(pred_taken),      0);
    lookup(0);
    check("lk0_ctr",   int'(pred_counter),    1);
    lookup(15);
    check("lk15_ctr",  int'(pred_counter),    1);

    // Saturation at the top and bottom.
    repeat (4) train(3, 1'b1);
    lookup(3);
    check("sat_hi_ctr",   int'(pred_counter), 3);
    check("sat_hi_taken", int'(pred_taken),   1);
    repeat (5) train(3, 1'b0);
    lookup(3);
    check("sat_lo_ctr",   int'(pred_counter), 0);

    // Same-index collision returns post-update value; other index unaffected.
    upd_valid = 1'b1; upd_index = 4'd7; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_index = 4'd7;
    tick();
    check("bypass_ctr",   int'(pred_counter), 2);
    check("bypass_taken", int'(pred_taken),   1);
    pred_index = 4'd8;
    tick();
    idle_inputs();
    check("nobypass_ctr", int'(pred_counter), 1);

    // Clear sweep: coincident update dropped, busy for DEPTH cycles.
    repeat (2) train(2, 1'b1);
    clear_req = 1'b1;
    upd_valid = 1'b1; upd_index = 4'd2; upd_taken = 1'b1;
    tick();
    idle_inputs();
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      check("busy_no_resp", int'(pred_resp_valid), 0);
      pred_valid = 1'b1;
      pred_index = 4'($urandom_range(0, DEPTH - 1));
      tick();
    end
    check("busy_cycles", busy_cycles, DEPTH);
    lookup(2);
    check("post_clear_ctr", int'(pred_counter), 1);

    // Reset in the middle of a sweep.
    for (int i = 7; i < DEPTH; i++) train(i, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rst_abort_busy", int'(busy), 0);
    for (int i = 0; i < DEPTH; i++) begin
      lookup(i);
      check("rst_abort_ctr", int'(pred_counter), INIT_VAL);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rstn       = ($urandom_range(0, 299) != 0);
      pred_valid = 1'($urandom_range(0, 1));
      pred_index = 4'($urandom_range(0, DEPTH - 1));
      upd_valid  = 1'($urandom_range(0, 1));
      upd_index  = ($urandom_range(0, 3) == 0) ? pred_index : 4'($urandom_range(0, DEPTH - 1));
      upd_taken  = 1'($urandom_range(0, 1));
      clear_req  = ($urandom_range(0, 63) == 0);
      tick();
    end
    rstn = 1'b1;
    idle_inputs();
    repeat (DEPTH + 2) tick();

    // Wider, shallower instance: 5 taken then 9 not-taken on one entry.
    p2_valid = 1'b1; p2_index = 2'd0;
    tick();
    check("p2_init_ctr",   int'(p2_counter), 3);
    check("p2_init_taken", int'(p2_taken),   0);
    e2 = 3;
    for (int k = 0; k < 14; k++) begin
      t = (k < 5);
      u2_valid = 1'b1; u2_index = 2'd1; u2_taken = t;
      p2_valid = 1'b1; p2_index = 2'd1;
      tick();
      e2 = t ? ((e2 < 7) ? e2 + 1 : 7) : ((e2 > 0) ? e2 - 1 : 0);
      check("p2_ctr",   int'(p2_counter),    e2);
      check("p2_taken", int'(p2_taken),      (e2 >= 4) ? 1 : 0);
      check("p2_valid", int'(p2_resp_valid), 1);
    end
    check("p2_final_ctr", int'(p2_counter), 0);
    u2_valid = 1'b0;
    p2_valid = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_sat_counter_table
`default_nettype wire
